// File: rtl/event_dispatch_ctrl.sv
// event_dispatch_ctrl: dispatches queued events to idle cores and re-enqueues messages returned by busy cores
module event_dispatch_ctrl #(
  parameter int NUM_CORE = 4,
  parameter int MSG_WID = 32,
  parameter int TIME_WID = 16,
  localparam int IW = $clog2(NUM_CORE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         q_empty,
  input  logic                         q_full,
  input  logic [MSG_WID-1:0]           q_data,
  output logic                         q_deq,
  output logic                         q_enq,
  output logic [MSG_WID-1:0]           q_enq_data,
  input  logic [NUM_CORE-1:0]          core_req,
  input  logic [NUM_CORE*MSG_WID-1:0]  core_out_msg,
  output logic [NUM_CORE-1:0]          core_ack,
  output logic [NUM_CORE-1:0]          core_in_vld,
  output logic [MSG_WID-1:0]           core_in_msg,
  output logic [MSG_WID-1:0]           mon_msg,
  output logic                         mon_sent_vld,
  output logic                         mon_rcv_vld,
  output logic [IW-1:0]                mon_core_id,
  output logic [NUM_CORE-1:0]          busy,
  output logic [31:0]                  disp_count
);
  typedef enum logic [1:0] {IDLE, RECV, DEQ, DISP} state_t;
  state_t state, st;
  logic [IW-1:0] rr_ptr, g, d, g_nxt, d_nxt;
  logic [NUM_CORE-1:0] elig, one;
  if (TIME_WID > MSG_WID || NUM_CORE < 2 || (1 << IW) != NUM_CORE) begin : g_bad_param
    $error("event_dispatch_ctrl: invalid parameters");
  end
  // reset forces the decoded view to IDLE so no strobe leaks out of an abandoned cycle
  assign st = reset ? IDLE : state;
  assign elig = core_req & busy;
  assign one = {{(NUM_CORE-1){1'b0}}, 1'b1};
  // round-robin return grant from rr_ptr upward, and lowest-index idle core for dispatch
  always_comb begin
    g_nxt = '0;
    d_nxt = '0;
    for (int i = NUM_CORE - 1; i >= 0; i--) begin
      if (elig[rr_ptr + IW'(i)]) g_nxt = rr_ptr + IW'(i);
      if (!busy[i]) d_nxt = IW'(i);
    end
  end
  // controller state, latched indices, busy bitmap and dispatch counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= '0;
      rr_ptr <= '0;
      g <= '0;
      d <= '0;
      disp_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|elig && !q_full) begin
            state <= RECV;
            g <= g_nxt;
          end else if (!q_empty && |(~busy)) begin
            state <= DEQ;
            d <= d_nxt;
          end
        end
        RECV: begin
          busy[g] <= 1'b0;
          rr_ptr <= g + 1'b1;
          state <= IDLE;
        end
        DEQ: state <= DISP;
        DISP: begin
          busy[d] <= 1'b1;
          disp_count <= disp_count + 32'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign q_deq = st == DEQ;
  assign q_enq = st == RECV;
  assign mon_rcv_vld = q_enq;
  assign mon_sent_vld = st == DISP;
  assign q_enq_data = q_enq ? core_out_msg[g*MSG_WID +: MSG_WID] : '0;
  assign core_ack = q_enq ? one << g : '0;
  assign core_in_vld = mon_sent_vld ? one << d : '0;
  assign core_in_msg = mon_sent_vld ? q_data : '0;
  assign mon_msg = q_enq ? q_enq_data : core_in_msg;
  assign mon_core_id = q_enq ? g : mon_sent_vld ? d : '0;
endmodule

// File: tb/tb_event_dispatch_ctrl.sv
// tb_event_dispatch_ctrl: directed self-checking bench for event_dispatch_ctrl
module tb_event_dispatch_ctrl;
  logic clk = 0, reset = 1, q_empty = 1, q_full = 0;
  logic [31:0] q_data = '0;
  logic q_deq, q_enq, mon_sent_vld, mon_rcv_vld;
  logic [31:0] q_enq_data, core_in_msg, mon_msg, disp_count;
  logic [3:0] core_req = '0, core_ack, core_in_vld, busy;
  logic [127:0] core_out_msg;
  logic [1:0] mon_core_id;
  int n_chk = 0, n_fail = 0;

  event_dispatch_ctrl dut (
    .clk(clk), .reset(reset), .q_empty(q_empty), .q_full(q_full), .q_data(q_data),
    .q_deq(q_deq), .q_enq(q_enq), .q_enq_data(q_enq_data), .core_req(core_req),
    .core_out_msg(core_out_msg), .core_ack(core_ack), .core_in_vld(core_in_vld),
    .core_in_msg(core_in_msg), .mon_msg(mon_msg), .mon_sent_vld(mon_sent_vld),
    .mon_rcv_vld(mon_rcv_vld), .mon_core_id(mon_core_id), .busy(busy), .disp_count(disp_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ret_msg(int k);
    return 32'hA000_0000 + 32'(k * 16 + 5);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    q_empty = 1;
    q_full = 0;
    core_req = '0;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic disp(input int idx, input logic [31:0] msg);
    q_empty = 0;
    q_data = msg;
    tick();
    chk("disp_q_deq", 64'(q_deq), 64'(1));
    q_empty = 1;
    tick();
    chk("disp_vld", 64'(core_in_vld), 64'(4'b0001 << idx));
    chk("disp_msg", 64'(core_in_msg), 64'(msg));
    chk("disp_mon_id", 64'(mon_core_id), 64'(idx));
    tick();
  endtask

  task automatic ret(input logic [3:0] req, input int idx);
    core_req = req;
    tick();
    chk("ret_ack", 64'(core_ack), 64'(4'b0001 << idx));
    chk("ret_enq", 64'(q_enq), 64'(1));
    chk("ret_enq_data", 64'(q_enq_data), 64'(ret_msg(idx)));
    chk("ret_mon", 64'({mon_rcv_vld, mon_core_id}), 64'({1'b1, 2'(idx)}));
    chk("ret_mon_msg", 64'(mon_msg), 64'(ret_msg(idx)));
    core_req = '0;
    tick();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) core_out_msg[k*32 +: 32] = ret_msg(k);
    do_reset();
    // reset state, with an unbusy core requesting (ignored)
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_count", 64'(disp_count), 64'(0));
    chk("rst_strobes", 64'({q_deq, q_enq, mon_sent_vld, mon_rcv_vld, core_ack, core_in_vld}), 64'(0));
    chk("rst_data", 64'({q_enq_data, mon_msg}), 64'(0));
    q_empty = 0;
    q_data = 32'h0003_0010;
    core_req = 4'b0010;
    tick();
    chk("first_q_deq", 64'(q_deq), 64'(1));
    chk("first_no_ack", 64'(core_ack), 64'(0));
    q_empty = 1;
    tick();
    chk("first_vld", 64'(core_in_vld), 64'(4'b0001));
    chk("first_msg", 64'(core_in_msg), 64'(32'h0003_0010));
    chk("first_mon", 64'({mon_sent_vld, mon_rcv_vld, mon_msg}), 64'({2'b10, 32'h0003_0010}));
    tick();
    chk("first_busy", 64'(busy), 64'(4'b0001));
    chk("first_count", 64'(disp_count), 64'(1));
    chk("ignored_req_ack", 64'(core_ack), 64'(0));
    core_req = '0;
    disp(1, 32'h11);
    disp(2, 32'h22);
    disp(3, 32'h33);
    chk("all_busy", 64'(busy), 64'(4'b1111));
    ret(4'b0010, 1);
    chk("after_ret1_busy", 64'(busy), 64'(4'b1101));
    disp(1, 32'h44);
    chk("refill_busy", 64'(busy), 64'(4'b1111));
    // rr_ptr is now 2: core 2 wins over core 0, then core 0 with core 2 no longer busy
    ret(4'b0101, 2);
    ret(4'b0101, 0);
    chk("rr_busy", 64'(busy), 64'(4'b1010));
    chk("rr_count", 64'(disp_count), 64'(5));
    // return beats dispatch in the same cycle
    do_reset();
    disp(0, 32'h1);
    disp(1, 32'h2);
    core_req = 4'b0001;
    q_empty = 0;
    q_data = 32'h55;
    tick();
    chk("prio_ack", 64'(core_ack), 64'(4'b0001));
    chk("prio_no_deq", 64'(q_deq), 64'(0));
    core_req = '0;
    tick();
    chk("prio_idle", 64'({q_deq, q_enq}), 64'(0));
    tick();
    chk("prio_deq", 64'(q_deq), 64'(1));
    q_empty = 1;
    tick();
    chk("prio_disp", 64'(core_in_vld), 64'(4'b0001));
    chk("prio_disp_msg", 64'(core_in_msg), 64'(32'h55));
    tick();
    chk("prio_busy", 64'(busy), 64'(4'b0011));
    chk("prio_count", 64'(disp_count), 64'(3));
    // q_full blocks returns
    do_reset();
    disp(0, 32'h7);
    q_full = 1;
    core_req = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("full_no_ack", 64'({core_ack, q_enq}), 64'(0));
    end
    q_full = 0;
    chk("full_drop_ack", 64'(core_ack), 64'(0));
    tick();
    chk("full_after_ack", 64'(core_ack), 64'(4'b0001));
    chk("full_after_enq", 64'(q_enq), 64'(1));
    core_req = '0;
    tick();
    chk("full_busy", 64'(busy), 64'(0));
    // reset during DISP abandons the event
    do_reset();
    q_empty = 0;
    q_data = 32'h99;
    tick();
    q_empty = 1;
    tick();
    reset = 1;
    #1;
    chk("rdisp_vld", 64'({core_in_vld, mon_sent_vld}), 64'(0));
    tick();
    reset = 0;
    chk("rdisp_busy", 64'(busy), 64'(0));
    chk("rdisp_count", 64'(disp_count), 64'(0));
    tick();
    chk("rdisp_idle", 64'(core_in_vld), 64'(0));
    // reset during DEQ abandons the event
    q_empty = 0;
    tick();
    reset = 1;
    q_empty = 1;
    #1;
    chk("rdeq_deq", 64'(q_deq), 64'(0));
    tick();
    reset = 0;
    tick();
    chk("rdeq_vld", 64'(core_in_vld), 64'(0));
    chk("rdeq_busy", 64'({busy, disp_count}), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
